sram_ctrl: RTL and testbench

Synchronous, parametrised controller for the asynchronous SRAM chips on the memory bus. It turns a one-cycle valid/ready request into a timed chip-enable / write-enable / output-enable sequence with programmable access length and read-to-write bus turnaround. It sits between the CPU memory stage and the board-level tri-state data pins. The top level keeps the pad tri-state: `data = ram_data_oe ? ram_data_out : 'z`.

---
 rtl/ram_pkg.sv | 25 ++
 rtl/sram_ctrl.sv | 150 +++++++++++++++
 tb/tb_sram_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// ram_pkg: state encoding, strobe polarities and helpers shared by the SRAM controller.
`default_nettype none

package ram_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    HOLD   = 3'd3,
    TURN   = 3'd4
  } ram_state_t;

  localparam logic CE_ACTIVE  = 1'b0;
  localparam logic CE2_ACTIVE = 1'b1;
  localparam logic WE_ACTIVE  = 1'b0;
  localparam logic OE_ACTIVE  = 1'b0;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram_ctrl.sv
// sram_ctrl: valid/ready request to timed CE/WE/OE sequence for asynchronous SRAM.
`default_nettype none

module sram_ctrl
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH  = 17,
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_CYCLES = 2,
  parameter int TURNAROUND  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  ram_chip_enable,
  output logic                  ram_chip_enable2,
  output logic                  ram_write_enable,
  output logic                  ram_output_enable,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_out,
  output logic                  ram_data_oe,
  input  logic [DATA_WIDTH-1:0] ram_data_in
);

  localparam int CNT_MAX = max_int(WAIT_CYCLES, TURNAROUND);
  localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);

  generate
    if (WAIT_CYCLES < 1) begin : g_wait_check
      $error("sram_ctrl: WAIT_CYCLES must be at least 1");
    end
    if (TURNAROUND < 0) begin : g_turn_check
      $error("sram_ctrl: TURNAROUND must not be negative");
    end
  endgenerate

  ram_state_t       state;
  ram_state_t       state_next;
  logic [CNT_W-1:0] cnt;
  logic             wr_flag;
  logic             access_last;

  assign access_last = (state == ACCESS) && (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS: begin
        if (access_last) begin
          if (wr_flag)             state_next = HOLD;
          else if (TURNAROUND > 0) state_next = TURN;
          else                     state_next = IDLE;
        end
      end
      HOLD:    state_next = IDLE;
      TURN:    if (cnt == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One counter serves both the strobe width and the read turnaround.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      case (state)
        SETUP:   cnt <= WAIT_LOAD;
        ACCESS:  cnt <= access_last ? TURN_LOAD : cnt - CNT_W'(1);
        TURN:    if (cnt != '0) cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_flag      <= 1'b0;
      ram_address  <= '0;
      ram_data_out <= '0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
    end else begin
      rsp_valid <= access_last;
      if (state == IDLE && req_valid) begin
        wr_flag      <= req_write;
        ram_address  <= req_addr;
        ram_data_out <= req_wdata;
      end
      if (access_last && !wr_flag) begin
        rsp_rdata <= ram_data_in;
      end
    end
  end

  // Strobes depend only on state and the captured write flag, never on req_*.
  always_comb begin
    req_ready         = 1'b0;
    ram_chip_enable   = ~CE_ACTIVE;
    ram_chip_enable2  = ~CE2_ACTIVE;
    ram_write_enable  = ~WE_ACTIVE;
    ram_output_enable = ~OE_ACTIVE;
    ram_data_oe       = 1'b0;
    case (state)
      IDLE: req_ready = 1'b1;
      SETUP: begin
        ram_chip_enable  = CE_ACTIVE;
        ram_chip_enable2 = CE2_ACTIVE;
        if (wr_flag) ram_data_oe       = 1'b1;
        else         ram_output_enable = OE_ACTIVE;
      end
      ACCESS: begin
        ram_chip_enable  = CE_ACTIVE;
        ram_chip_enable2 = CE2_ACTIVE;
        if (wr_flag) begin
          ram_write_enable = WE_ACTIVE;
          ram_data_oe      = 1'b1;
        end else begin
          ram_output_enable = OE_ACTIVE;
        end
      end
      HOLD: begin
        ram_chip_enable  = CE_ACTIVE;
        ram_chip_enable2 = CE2_ACTIVE;
        ram_data_oe      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: three controller configurations against SRAM models and a timing/data reference.
`default_nettype none

module tb_sram_ctrl;

  localparam int NI = 3;

  logic clk;
  logic rst;

  logic [NI-1:0]       v_valid;
  logic [NI-1:0]       v_write;
  logic [NI-1:0][16:0] v_addr;
  logic [NI-1:0][15:0] v_wdata;

  wire [NI-1:0]       v_ready;
  wire [NI-1:0]       v_rsp;
  wire [NI-1:0]       v_ce_n;
  wire [NI-1:0]       v_ce2;
  wire [NI-1:0]       v_we_n;
  wire [NI-1:0]       v_oe_n;
  wire [NI-1:0]       v_doe;
  wire [NI-1:0][16:0] v_addr_o;
  wire [NI-1:0][15:0] v_dout;
  wire [NI-1:0][15:0] v_rdata;

  int vectors;
  int miscompares;

  logic [15:0] mdl [int unsigned];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int wait_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
  endfunction

  function automatic int turn_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  function automatic logic [16:0] amask(input int k);
    return (k == 0) ? 17'h1FFFF : 17'h000FF;
  endfunction

  function automatic logic [15:0] dmask(input int k);
    return (k == 0) ? 16'h00FF : 16'hFFFF;
  endfunction

  generate
    for (genvar k = 0; k < NI; k++) begin : g_inst
      localparam int W  = (k == 0) ? 2 : ((k == 1) ? 1 : 4);
      localparam int T  = (k == 0) ? 1 : ((k == 1) ? 0 : 3);
      localparam int AW = (k == 0) ? 17 : 8;
      localparam int DW = (k == 0) ? 8 : 16;

      logic          ready, rsp, ce_n, ce2, we_n, oe_n, doe;
      logic [AW-1:0] a_o;
      logic [DW-1:0] rdata, dout, din;
      logic [DW-1:0] mem [0:(1<<AW)-1];

      sram_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .WAIT_CYCLES(W),
        .TURNAROUND (T)
      ) u_dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (v_valid[k]),
        .req_ready        (ready),
        .req_write        (v_write[k]),
        .req_addr         (v_addr[k][AW-1:0]),
        .req_wdata        (v_wdata[k][DW-1:0]),
        .rsp_valid        (rsp),
        .rsp_rdata        (rdata),
        .ram_chip_enable  (ce_n),
        .ram_chip_enable2 (ce2),
        .ram_write_enable (we_n),
        .ram_output_enable(oe_n),
        .ram_address      (a_o),
        .ram_data_out     (dout),
        .ram_data_oe      (doe),
        .ram_data_in      (din)
      );

      assign v_ready[k]  = ready;
      assign v_rsp[k]    = rsp;
      assign v_ce_n[k]   = ce_n;
      assign v_ce2[k]    = ce2;
      assign v_we_n[k]   = we_n;
      assign v_oe_n[k]   = oe_n;
      assign v_doe[k]    = doe;
      assign v_addr_o[k] = 17'(a_o);
      assign v_dout[k]   = 16'(dout);
      assign v_rdata[k]  = 16'(rdata);

      // Asynchronous SRAM: drives only while selected with OE low, otherwise reads as all ones.
      initial for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
      always @(posedge clk) if (!ce_n && ce2 && !we_n && doe) mem[a_o] <= dout;
      assign din = (!ce_n && ce2 && !oe_n) ? mem[a_o] : {DW{1'b1}};

      always @(negedge clk) begin
        chk("we_oe_overlap", {31'd0, !we_n && !oe_n}, 32'd0);
        chk("oe_doe_overlap", {31'd0, !oe_n && doe}, 32'd0);
      end
    end
  endgenerate

  task automatic txn(input int k, input logic wr, input logic [16:0] a_in, input logic [15:0] d_in);
    int w, t, c, rsp_c, rsp_n, we_c, oe_c, doe_c, rdy_c, bad_a;
    logic [16:0] a;
    logic [15:0] d, got, exp_rd;
    int unsigned key;
    w = wait_of(k);
    t = turn_of(k);
    a = a_in & amask(k);
    d = d_in & dmask(k);
    key = (k << 20) | a;
    exp_rd = mdl.exists(key) ? mdl[key] : 16'h0000;
    c = 0;
    while (!v_ready[k] && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("ready_wait", (c < 100) ? 32'd1 : 32'd0, 32'd1);
    v_write[k] = wr;
    v_addr[k]  = a;
    v_wdata[k] = d;
    v_valid[k] = 1'b1;
    @(posedge clk);
    #1;
    v_valid[k] = 1'b0;
    if (wr) mdl[key] = d;
    c = 1; rsp_c = 0; rsp_n = 0; we_c = 0; oe_c = 0; doe_c = 0; rdy_c = 0; bad_a = 0;
    got = '0;
    while (rdy_c == 0 && c < 100) begin
      @(negedge clk);
      if (v_rsp[k]) begin
        rsp_n++;
        rsp_c = c;
        got = v_rdata[k];
      end
      if (!v_we_n[k]) we_c++;
      if (!v_oe_n[k]) oe_c++;
      if (v_doe[k]) doe_c++;
      if (!v_ce_n[k] && v_addr_o[k] !== a) bad_a++;
      if (v_ready[k]) rdy_c = c;
      else c++;
    end
    chk("rsp_count", rsp_n, 1);
    chk("rsp_cycle", rsp_c, 2 + w);
    chk("ready_cycle", rdy_c, wr ? 3 + w : 2 + w + t);
    chk("we_low_cycles", we_c, wr ? w : 0);
    chk("oe_low_cycles", oe_c, wr ? 0 : w + 1);
    chk("data_oe_cycles", doe_c, wr ? w + 2 : 0);
    chk("addr_stable", bad_a, 0);
    if (!wr) chk("rdata", got, exp_rd);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acc, n_rsp, cyc, last_rdy, cnt;
    logic prev_wr, pend_rd, wr;
    logic [15:0] pend_exp, dd;
    logic [16:0] ad;
    int unsigned key;

    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    v_valid = '0;
    v_write = '0;
    v_addr = '0;
    v_wdata = '0;
    repeat (3) @(negedge clk);

    for (int k = 0; k < NI; k++) begin
      chk("rst_ready", v_ready[k], 1);
      chk("rst_rsp", v_rsp[k], 0);
      chk("rst_ce", v_ce_n[k], 1);
      chk("rst_ce2", v_ce2[k], 0);
      chk("rst_we", v_we_n[k], 1);
      chk("rst_oe", v_oe_n[k], 1);
      chk("rst_doe", v_doe[k], 0);
      chk("rst_addr", v_addr_o[k], 0);
      chk("rst_dout", v_dout[k], 0);
      chk("rst_rdata", v_rdata[k], 0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Directed write then read-back, then read immediately followed by a write.
    txn(0, 1'b1, 17'h1A5F, 16'h00C3);
    txn(0, 1'b0, 17'h1A5F, 16'h0000);
    txn(0, 1'b0, 17'h1A5F, 16'h0000);
    txn(0, 1'b1, 17'h0ABC, 16'h0077);
    txn(0, 1'b0, 17'h0ABC, 16'h0000);

    // Request held valid, alternating write/read.
    n_acc = 0; n_rsp = 0; cyc = 0; last_rdy = -1;
    prev_wr = 1'b0; pend_rd = 1'b0; pend_exp = '0;
    while (cyc < 40) begin
      if (v_rsp[0]) begin
        n_rsp++;
        if (pend_rd) chk("cont_rdata", v_rdata[0], pend_exp);
      end
      if (v_ready[0]) begin
        if (last_rdy >= 0)
          chk("cont_interval", cyc - last_rdy, prev_wr ? wait_of(0) + 3 : 2 + wait_of(0) + turn_of(0));
        last_rdy = cyc;
        wr = (n_acc % 2 == 0);
        ad = 17'h00200 + 17'(n_acc / 2);
        key = ad;
        dd = 16'($urandom) & 16'h00FF;
        if (wr) begin
          mdl[key] = dd;
          pend_rd = 1'b0;
        end else begin
          pend_rd = 1'b1;
          pend_exp = mdl.exists(key) ? mdl[key] : 16'h0000;
        end
        v_write[0] = wr;
        v_addr[0]  = ad;
        v_wdata[0] = dd;
        v_valid[0] = 1'b1;
        prev_wr = wr;
        n_acc++;
      end
      @(negedge clk);
      cyc++;
    end
    v_valid[0] = 1'b0;
    cnt = 0;
    while (cnt < 50) begin
      if (v_rsp[0]) begin
        n_rsp++;
        if (pend_rd) chk("cont_rdata", v_rdata[0], pend_exp);
      end
      if (v_ready[0]) break;
      @(negedge clk);
      cnt++;
    end
    chk("cont_drain", (cnt < 50) ? 32'd1 : 32'd0, 32'd1);
    chk("cont_accepts", n_acc, 8);
    chk("cont_rsp_count", n_rsp, n_acc);

    // Reset in the middle of a write strobe.
    v_write[0] = 1'b1;
    v_addr[0]  = 17'h00777;
    v_wdata[0] = 16'h005A;
    v_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    v_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_we", v_we_n[0], 0);
    rst = 1'b1;
    #1;
    chk("arst_we", v_we_n[0], 1);
    chk("arst_ce", v_ce_n[0], 1);
    chk("arst_ce2", v_ce2[0], 0);
    chk("arst_oe", v_oe_n[0], 1);
    chk("arst_doe", v_doe[0], 0);
    chk("arst_ready", v_ready[0], 1);
    chk("arst_rsp", v_rsp[0], 0);
    chk("arst_addr", v_addr_o[0], 0);
    chk("arst_dout", v_dout[0], 0);
    chk("arst_rdata", v_rdata[0], 0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (v_rsp[0]) cnt++;
    end
    chk("abort_rsp", cnt, 0);
    txn(0, 1'b1, 17'h00321, 16'h0099);
    txn(0, 1'b0, 17'h00321, 16'h0000);

    // Other configurations: 16-bit round trip.
    for (int k = 1; k < NI; k++) begin
      txn(k, 1'b1, 17'h0005A, 16'hBEEF);
      txn(k, 1'b0, 17'h0005A, 16'h0000);
    end

    // Randomized traffic on every configuration over a small address pool.
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 12; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        txn(k, 1'($urandom), 17'h00040 + 17'($urandom_range(0, 5) * 3), 16'($urandom));
      end
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
